// File: rtl/paddle_engine_if.sv
// Paddle engine bus: move/draw request inputs and pixel-plot / status outputs.
interface paddle_if;
    logic       left;
    logic       right;
    logic       enable;
    logic       draw_req;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic [9:0] pad_x;

    modport master (
        output left, right, enable, draw_req,
        input  x, y, colour, plot, busy, done, pad_x
    );

    modport slave (
        input  left, right, enable, draw_req,
        output x, y, colour, plot, busy, done, pad_x
    );
endinterface

// File: rtl/paddle_engine.sv
// Paddle engine: per frame erases the old paddle, moves it one step, redraws it.
// Build option PADDLE_ERASE_EN enables the erase pass; without it frames go straight to MOVE.
module paddle_engine #(
    parameter int unsigned PAD_W  = 16,
    parameter int unsigned PAD_H  = 2,
    parameter int unsigned STEP   = 2,
    parameter int unsigned X_MAX  = 159,
    parameter int unsigned X_INIT = 32,
    parameter int unsigned Y_POS  = 64,
    parameter logic [2:0]  COLOUR = 3'b100
) (
    input logic      clk,
    input logic      resetn,
    paddle_if.slave  bus
);
    localparam int unsigned AW = 11;
    localparam int unsigned CW = 6;
    localparam int unsigned RW = 3;
    localparam logic [AW-1:0] STEP_A   = AW'(STEP);
    localparam logic [AW-1:0] LIMIT_A  = AW'(X_MAX - PAD_W + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(PAD_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PAD_H - 1);

    typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   col, col_nx;
    logic [RW-1:0]   row, row_nx;
    logic [9:0]      pad, pad_nx;
    logic            go_l, go_l_nx;
    logic            go_r, go_r_nx;
    logic [AW-1:0]   pad_a_c;
    logic [AW-1:0]   sum_c;

    logic [9:0]      x_c;
    logic [9:0]      y_c;
    logic [2:0]      colour_c;
    logic            plot_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            pad   <= 10'(X_INIT);
            go_l  <= 1'b0;
            go_r  <= 1'b0;
        end else begin
            state <= state_nx;
            col   <= col_nx;
            row   <= row_nx;
            pad   <= pad_nx;
            go_l  <= go_l_nx;
            go_r  <= go_r_nx;
        end
    end

    // Next-state: accept in IDLE, row-major pixel scan, clamped move.
    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        pad_nx   = pad;
        go_l_nx  = go_l;
        go_r_nx  = go_r;
        pad_a_c  = AW'(pad);
        sum_c    = AW'(pad) + STEP_A;

        case (state)
            IDLE: begin
                if (bus.draw_req) begin
                    go_l_nx = bus.enable & bus.left  & ~bus.right;
                    go_r_nx = bus.enable & bus.right & ~bus.left;
                    col_nx  = '0;
                    row_nx  = '0;
`ifdef PADDLE_ERASE_EN
                    state_nx = ERASE;
`else
                    state_nx = MOVE;
`endif
                end
            end
            ERASE, DRAW: begin
                if (col == COL_LAST) begin
                    col_nx = '0;
                    if (row == ROW_LAST) begin
                        row_nx   = '0;
                        state_nx = (state == ERASE) ? MOVE : DONE;
                    end else begin
                        row_nx = row + RW'(1);
                    end
                end else begin
                    col_nx = col + CW'(1);
                end
            end
            MOVE: begin
                if (go_l) begin
                    pad_nx = (pad_a_c < STEP_A) ? 10'(0) : 10'(pad_a_c - STEP_A);
                end else if (go_r) begin
                    pad_nx = (sum_c > LIMIT_A) ? 10'(LIMIT_A) : 10'(sum_c);
                end
                state_nx = DRAW;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore output decode from state and scan counters.
    always_comb begin
        x_c      = pad;
        y_c      = 10'(Y_POS);
        colour_c = 3'b000;
        plot_c   = 1'b0;
        if (state == ERASE || state == DRAW) begin
            plot_c = 1'b1;
            x_c    = 10'(AW'(pad) + AW'(col));
            y_c    = 10'(AW'(Y_POS) + AW'(row));
        end
        if (state == DRAW) begin
            colour_c = COLOUR;
        end
    end

    assign bus.x      = x_c;
    assign bus.y      = y_c;
    assign bus.colour = colour_c;
    assign bus.plot   = plot_c;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.pad_x  = pad;

endmodule

// File: tb/tb_paddle_engine.sv
// Bench for paddle_engine: three instances (X_INIT 32, 143, 1) driven in lockstep,
// every cycle compared against a frame-trace model built from the movement rules.
module tb_paddle_engine;
    localparam int NI    = 3;
    localparam int PAD_W = 16;
    localparam int PAD_H = 2;
    localparam int STEP  = 2;
    localparam int X_MAX = 159;
    localparam int Y_POS = 64;
    localparam int N     = PAD_W * PAD_H;
    localparam logic [2:0] COLOUR = 3'b100;
`ifdef PADDLE_ERASE_EN
    localparam int E = N;
`else
    localparam int E = 0;
`endif
    localparam int DONE_K = E + N + 2;
    localparam logic [35:0] XY_MASK = {6'h3f, 20'h0, 10'h3ff};

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic left = 1'b0, right = 1'b0, enable = 1'b0, draw_req = 1'b0;
    logic [NI-1:0][35:0] obs;

    int checks = 0;
    int fails  = 0;
    int pad_m [NI];
    int old_m [NI];
    int new_m [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        paddle_if bus ();
        paddle_engine #(.X_INIT((g == 0) ? 32 : (g == 1) ? 143 : 1)) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (bus)
        );
        assign bus.left     = left;
        assign bus.right    = right;
        assign bus.enable   = enable;
        assign bus.draw_req = draw_req;
        assign obs[g] = {bus.plot, bus.busy, bus.done, bus.colour, bus.x, bus.y, bus.pad_x};
    end

    function automatic int x_init(int i);
        return (i == 0) ? 32 : (i == 1) ? 143 : 1;
    endfunction

    function automatic int next_pad(int p, bit l, bit r, bit en);
        if (en && l && !r) return (p < STEP) ? 0 : p - STEP;
        if (en && r && !l) return (p + STEP > X_MAX - PAD_W + 1) ? X_MAX - PAD_W + 1 : p + STEP;
        return p;
    endfunction

    function automatic logic [35:0] pack(bit p, bit b, bit d, logic [2:0] c, int x, int y, int pd);
        return {p, b, d, c, 10'(x), 10'(y), 10'(pd)};
    endfunction

    // Expected outputs k cycles after the accepting edge of a frame.
    function automatic logic [35:0] expect_at(int k, int oldp, int newp);
        int idx;
        if (k <= E) begin
            idx = k - 1;
            return pack(1, 1, 0, 3'b000, oldp + idx % PAD_W, Y_POS + idx / PAD_W, oldp);
        end
        if (k == E + 1) return pack(0, 1, 0, 3'b000, oldp, Y_POS, oldp);
        if (k <= E + 1 + N) begin
            idx = k - E - 2;
            return pack(1, 1, 0, COLOUR, newp + idx % PAD_W, Y_POS + idx / PAD_W, newp);
        end
        if (k == DONE_K) return pack(0, 1, 1, 3'b000, newp, Y_POS, newp);
        return pack(0, 0, 0, 3'b000, newp, Y_POS, newp);
    endfunction

    task automatic check_cycle(string tag, int k);
        logic [35:0] want, got, mask;
        for (int i = 0; i < NI; i++) begin
            mask = (k == DONE_K) ? XY_MASK : '1;
            want = expect_at(k, old_m[i], new_m[i]) & mask;
            got  = obs[i] & mask;
            checks++;
            assert (got === want) else begin
                fails++;
                $error("FAIL %s inst%0d k=%0d observed=%h expected=%h", tag, i, k, got, want);
            end
        end
    endtask

    task automatic check_idle(string tag);
        for (int i = 0; i < NI; i++) begin
            old_m[i] = pad_m[i];
            new_m[i] = pad_m[i];
        end
        check_cycle(tag, 1000);
    endtask

    // Caller is at a negedge in IDLE; returns at a negedge in IDLE after the frame.
    task automatic run_frame(string tag, bit l, bit r, bit en, bit keep, int abort_k);
        left = l; right = r; enable = en; draw_req = 1'b1;
        for (int i = 0; i < NI; i++) begin
            old_m[i] = pad_m[i];
            new_m[i] = next_pad(pad_m[i], l, r, en);
        end
        for (int k = 1; k <= DONE_K + 1; k++) begin
            @(negedge clk);
            check_cycle(tag, k);
            if (k == abort_k) begin
                #1 resetn = 1'b0;
                #1;
                for (int i = 0; i < NI; i++) begin
                    pad_m[i] = x_init(i);
                end
                check_idle("reset_mid_draw");
                @(negedge clk);
                draw_req = 1'b0;
                resetn = 1'b1;
                check_idle("after_abort");
                return;
            end
            if (k <= DONE_K) begin
                draw_req = keep ? 1'b1 : 1'($urandom_range(0, 1));
                left     = 1'($urandom_range(0, 1));
                right    = 1'($urandom_range(0, 1));
                enable   = 1'($urandom_range(0, 1));
            end else begin
                draw_req = 1'b0;
            end
        end
        for (int i = 0; i < NI; i++) pad_m[i] = new_m[i];
    endtask

    initial begin
        for (int i = 0; i < NI; i++) pad_m[i] = x_init(i);
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_idle("idle_after_reset");
        end

        run_frame("right_first", 1, 0, 1, 0, -1);
        run_frame("left_back", 1'b1, 1'b0, 1'b1, 0, -1);
        run_frame("left_to_zero", 1'b1, 1'b0, 1'b1, 0, -1);
        run_frame("both_dirs", 1'b1, 1'b1, 1'b1, 0, -1);
        run_frame("disabled", 1'b0, 1'b1, 1'b0, 0, -1);
        run_frame("held_req_a", 1'b0, 1'b1, 1'b1, 1, -1);
        run_frame("held_req_b", 1'b0, 1'b1, 1'b1, 1, -1);
        @(negedge clk);
        check_idle("idle_after_held");
        repeat (10) begin
            run_frame("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
        run_frame("abort", 1'b0, 1'b1, 1'b1, 0, E + 2 + 10);
        run_frame("after_reset_right", 1'b0, 1'b1, 1'b1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/paddle_engine.md
PADDLE_ENGINE -- requirements
Module: paddle_engine

Interface
REQ-001 Parameter PAD_W, default 16, paddle width in pixels (1..64).
REQ-002 Parameter PAD_H, default 2, paddle height in pixels (1..8).
REQ-003 Parameter STEP, default 2, pixels moved per accepted move.
REQ-004 Parameter X_MAX, default 159, rightmost screen column.
REQ-005 Parameter X_INIT, default 32, paddle left edge after reset.
REQ-006 Parameter Y_POS, default 64, paddle top row (fixed).
REQ-007 Parameter COLOUR, default 3'b100, paddle draw colour.
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 resetn  input  1  reset; asynchronous, active-low.
REQ-010 left  input  1  move-left request, sampled at acceptance.
REQ-011 right  input  1  move-right request, sampled at acceptance.
REQ-012 enable  input  1  movement enable, sampled at acceptance.
REQ-013 draw_req  input  1  start one erase/move/draw frame.
REQ-014 x  output  10  pixel column to plot.
REQ-015 y  output  10  pixel row to plot.
REQ-016 colour  output  3  pixel colour to plot.
REQ-017 plot  output  1  pixel write strobe (x, y, colour valid).
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse at frame end.
REQ-020 pad_x  output  10  current paddle left edge, for collision logic.

Function
REQ-021 FSM states SHALL be IDLE, ERASE, MOVE, DRAW, DONE; outputs decoded Moore-style from state and counters.
REQ-022 In IDLE, draw_req=1 at a rising edge SHALL be accepted: left, right, enable latched; next state ERASE.
REQ-023 draw_req while busy SHALL be ignored; no queuing.
REQ-024 ERASE SHALL last N=PAD_W*PAD_H cycles, plot=1, colour=0, pixels of the old pad_x, then go to MOVE.
REQ-025 Pixel scan SHALL be row-major: column counter 0..PAD_W-1 inner, row counter 0..PAD_H-1 outer; x=pad_x+col, y=Y_POS+row.
REQ-026 MOVE SHALL last one cycle, plot=0, updating pad_x per REQ-027..029, then go to DRAW.
REQ-027 Latched enable&left&!right: pad_x <= (pad_x<STEP) ? 0 : pad_x-STEP.
REQ-028 Latched enable&right&!left: pad_x <= min(pad_x+STEP, X_MAX-PAD_W+1).
REQ-029 Both or neither direction, or enable=0: pad_x unchanged; frame still runs.
REQ-030 DRAW SHALL last N cycles, plot=1, colour=COLOUR, pixels of new pad_x, then go to DONE.
REQ-031 DONE SHALL last one cycle, done=1, plot=0, then go to IDLE; draw_req in DONE is ignored.
REQ-032 Frame latency: acceptance edge to done high SHALL be exactly 2N+1 cycles; busy high 2N+2 cycles.
REQ-033 In IDLE and MOVE, x and y SHALL hold pad_x and Y_POS, colour=0, plot=0.
REQ-034 Internal arithmetic SHALL be 11 bits wide so clamping never wraps.

Reset
REQ-035 resetn low SHALL immediately, regardless of clk, force state IDLE, counters 0, pad_x=X_INIT, plot=0, busy=0, done=0, colour=0.
REQ-036 Reset mid-frame SHALL abort it; partial pixels are not completed; first frame after release starts from X_INIT.

Configuration
REQ-037 Macro PADDLE_ERASE_EN defined: ERASE state present as above.
REQ-038 PADDLE_ERASE_EN undefined: ERASE removed; acceptance goes directly to MOVE; latency N+1 cycles to done, busy N+2 cycles.

Verification
REQ-039 Reset release, idle 5 cycles -> pad_x=32, plot=0, busy=0, done=0.
REQ-040 Defaults, right=1, enable=1, draw_req pulse -> 32 erase plots x=32..47 y=64..65 colour 0, MOVE, 32 draw plots x=34..49 colour 4, done at cycle 65, pad_x=34.
REQ-041 pad_x=143, right move -> pad_x clamps to 144; pad_x=1, left move -> pad_x=0.
REQ-042 left=1 and right=1, enable=1 -> pad_x unchanged, full 66-cycle frame, erase/draw pixels identical.
REQ-043 draw_req held high during frame -> exactly one done pulse per accepted request; next frame starts only from IDLE.
REQ-044 resetn asserted at DRAW pixel 10 -> plot low within same cycle, pad_x=32, busy=0; without PADDLE_ERASE_EN frame done at cycle 33.
